ad1_sample_ctrl: RTL and testbench
==================================

Name: ad1_sample_ctrl

Overview:
- Sequences the Pmod AD1 dual 12-bit ADC for the drum-pad front end.
- Generates SCLK and CS from the system clock and runs one 16-bit conversion frame per sample period.
- Shifts in both data lines and presents two 12-bit samples with a valid strobe.
- Flags drum hits per channel using a threshold and a retrigger holdoff; downstream scoring logic consumes DVALID/HIT0/HIT1.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (≥2); 100 MHz → 12.5 MHz SCLK
- SAMPLE_PERIOD, 2000, system clocks between frame requests (≥ 32*CLK_DIV+QUIET_CYC+2)
- QUIET_CYC, 6, minimum system clocks CS stays high between frames (≥1)
- HIT_THRESH, 800, 12-bit level at or above which a sample counts as a hit
- HOLDOFF, 500, samples per channel ignored after a hit (≥1)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  enables periodic sampling; low = no new frames
- START  in  1  one-cycle request for an extra frame (also works with EN low)
- SDATA0  in  1  ADC channel 0 serial data
- SDATA1  in  1  ADC channel 1 serial data
- SCLK  out  1  ADC serial clock, idles high
- CS  out  1  ADC chip select, active low
- DATA0  out  12  last channel 0 sample
- DATA1  out  12  last channel 1 sample
- DVALID  out  1  one-cycle pulse when DATA0/DATA1 update
- FRAME_ERR  out  1  pulse with DVALID when a leading bit was non-zero
- HIT0  out  1  one-cycle pulse, channel 0 hit
- HIT1  out  1  one-cycle pulse, channel 1 hit
- BUSY  out  1  high in FRAME or QUIET

Behaviour:
- Reset (async, immediate): state IDLE; CS=1, SCLK=1, DATA0=DATA1=0, DVALID=FRAME_ERR=HIT0=HIT1=BUSY=0; all counters, the pending flag and the holdoff counters cleared.
- Period counter: free-runs 0..SAMPLE_PERIOD-1 while EN=1, held at 0 while EN=0. At the wrap it sets `pending`.
- A START pulse also sets `pending`. Requests are coalesced: `pending` is one bit deep.
- All outputs are registered.
- IDLE -> FRAME when `pending`=1, clearing `pending` the same cycle. The cycle after entry, CS=0 and SCLK=1.
- FRAME:
  - Half-period counter toggles SCLK every CLK_DIV clocks; the first toggle is high→low, CLK_DIV clocks after CS falls.
  - On each clock where SCLK goes 0→1, the block shifts SDATA0 and SDATA1 (MSB first) into 16-bit shift registers and increments the bit counter.
  - After the 16th rise, SCLK stays high and the block moves to QUIET.
  - Frame length from CS low to the 16th rise is 32*CLK_DIV clocks.
- QUIET:
  - CS=1 on entry.
  - In the entry cycle: DATA0 = shift0[11:0], DATA1 = shift1[11:0], and DVALID pulses.
  - FRAME_ERR = OR of shift0[15:12] and shift1[15:12].
  - Stays in QUIET for QUIET_CYC clocks, then returns to IDLE.
  - If `pending` is set at that point, the next frame starts immediately.
- Requests arriving during FRAME or QUIET set `pending`; they are never dropped beyond coalescing.
- EN falling mid-frame: the frame completes normally, DVALID still fires, and no further periodic frames start.
- Hit detection (per channel, evaluated in the DVALID cycle):
  - HITn=1 when the new sample ≥ HIT_THRESH and holdoffn=0. holdoffn is then loaded with HOLDOFF.
  - Otherwise, if holdoffn>0, it decrements by 1 on that DVALID.
  - HIT and the load/decrement use the same sample.
- Samples are unsigned. Comparisons are 12-bit unsigned. There is no arithmetic wrap beyond the counters.
- BUSY = state≠IDLE.

Decomposition:
- Shared package `ad1_pkg` holds:
  - state encoding: IDLE, FRAME, QUIET
  - ADC_BITS=12, FRAME_BITS=16, LEAD_ZEROS=4
- One sub-module, `hit_holdoff`, instantiated twice (one per channel): threshold compare plus holdoff counter, with inputs sample, valid and outputs hit.

Test Plan:
- CLK_DIV=2, EN=0, START pulse; ADC model drives 0x0ABC on ch0 and 0x0123 on ch1 -> CS low for 64 clocks, exactly 16 SCLK rises, DVALID once, DATA0=0xABC, DATA1=0x123, FRAME_ERR=0.
- EN=1, SAMPLE_PERIOD=200, run 2000 clocks -> exactly 10 DVALID pulses spaced 200 clocks apart; CS high ≥ QUIET_CYC between frames.
- ch0 model word 0x8FFF -> DATA0=0xFFF, FRAME_ERR=1 coincident with DVALID.
- HIT_THRESH=800, HOLDOFF=3, ch0 sample sequence 900,900,900,900,900 -> HIT0 on samples 1 and 5 only; ch1 fixed at 100 -> HIT1 never.
- START pulses twice during an active frame -> exactly one extra frame follows, with QUIET_CYC gap honoured.
- RESET asserted after the 7th SCLK rise -> CS=1, SCLK=1 at once, no DVALID; after release with EN=1, the first frame starts after a full SAMPLE_PERIOD with correct data.

Source files
------------

// File: rtl/ad1_pkg.sv
// Shared constants, state encoding and helpers for the Pmod AD1 sampling controller.
package ad1_pkg;

  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_QUIET = 2'd2;

  // The AD1 clocks out four zero bits ahead of the sample; anything else is a broken frame.
  function automatic logic lead_err(input logic [FRAME_BITS-1:0] w);
    return |w[FRAME_BITS-1 -: LEAD_ZEROS];
  endfunction

endpackage

// File: rtl/ad1_sample_ctrl_if.sv
// Control, serial ADC pins and sample/hit outputs of the AD1 sampling controller.
interface ad1_sample_ctrl_if;
  import ad1_pkg::*;

  logic                en;
  logic                start;
  logic                sdata0;
  logic                sdata1;
  logic                sclk;
  logic                cs;
  logic [ADC_BITS-1:0] data0;
  logic [ADC_BITS-1:0] data1;
  logic                dvalid;
  logic                frame_err;
  logic                hit0;
  logic                hit1;
  logic                busy;

  modport master (
    output en, start, sdata0, sdata1,
    input  sclk, cs, data0, data1, dvalid, frame_err, hit0, hit1, busy
  );

  modport slave (
    input  en, start, sdata0, sdata1,
    output sclk, cs, data0, data1, dvalid, frame_err, hit0, hit1, busy
  );

endinterface

// File: rtl/ad1_sample_ctrl_hit_holdoff.sv
// Per-channel drum hit detector: threshold compare with a retrigger holdoff counted in samples.
module hit_holdoff
  import ad1_pkg::*;
#(
  parameter int HIT_THRESH = 800,
  parameter int HOLDOFF    = 500
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADC_BITS-1:0] i_sample,
  input  logic                i_valid,
  output logic                o_hit
);

  localparam int                  HW        = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0]       HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [ADC_BITS-1:0] THRESH    = ADC_BITS'(HIT_THRESH);

  logic [HW-1:0] r_holdoff;
  logic          r_hit;
  logic          w_fire;

  assign w_fire = i_valid && (i_sample >= THRESH) && (r_holdoff == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_holdoff <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_hit <= w_fire;
      if (w_fire)
        r_holdoff <= HOLD_LOAD;
      else if (i_valid && (r_holdoff != '0))
        r_holdoff <= r_holdoff - HW'(1);
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/ad1_sample_ctrl.sv
// Pmod AD1 frame sequencer: periodic/explicit conversion requests, SCLK/CS generation,
// dual-line capture, and per-channel hit flags for the drum-pad front end.
//   state | meaning
//   IDLE  | CS high, waiting for a pending request
//   FRAME | CS low, 16 SCLK periods, data shifted on each SCLK rise
//   QUIET | CS high for QUIET_CYC clocks; DVALID in its first cycle
module ad1_sample_ctrl
  import ad1_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int QUIET_CYC     = 6,
  parameter int HIT_THRESH    = 800,
  parameter int HOLDOFF       = 500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ad1_sample_ctrl_if.slave   io_adc
);

  localparam int                PER_W      = $clog2(SAMPLE_PERIOD);
  localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
  localparam int                DIV_W      = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD   = DIV_W'(CLK_DIV - 1);
  localparam int                QUIET_W    = $clog2(QUIET_CYC + 1);
  localparam logic [QUIET_W-1:0] QUIET_LOAD = QUIET_W'(QUIET_CYC - 1);
  localparam int                BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [PER_W-1:0]      r_per_cnt;
  logic                  r_pending;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [QUIET_W-1:0]    r_quiet_cnt;
  logic [FRAME_BITS-2:0] r_shift0;
  logic [FRAME_BITS-2:0] r_shift1;
  logic                  r_sclk;
  logic                  r_cs;
  logic [ADC_BITS-1:0]   r_data0;
  logic [ADC_BITS-1:0]   r_data1;
  logic                  r_dvalid;
  logic                  r_frame_err;
  logic                  r_busy;

  logic                  w_wrap;
  logic                  w_launch;
  logic                  w_quiet_done;
  logic                  w_rise;
  logic                  w_last;
  logic [FRAME_BITS-1:0] w_word0;
  logic [FRAME_BITS-1:0] w_word1;

  assign w_wrap       = io_adc.en && (r_per_cnt == PER_LAST);
  assign w_quiet_done = (r_state == ST_QUIET) && (r_quiet_cnt == '0);
  assign w_launch     = r_pending && ((r_state == ST_IDLE) || w_quiet_done);
  assign w_rise       = (r_state == ST_FRAME) && (r_div_cnt == '0) && !r_sclk;
  assign w_last       = w_rise && (r_bit_cnt == BIT_LAST);
  assign w_word0      = {r_shift0, io_adc.sdata0};
  assign w_word1      = {r_shift1, io_adc.sdata1};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_pending) w_state_nxt = ST_FRAME;
      ST_FRAME: if (w_last) w_state_nxt = ST_QUIET;
      ST_QUIET: if (w_quiet_done) w_state_nxt = r_pending ? ST_FRAME : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_per_cnt   <= '0;
      r_pending   <= 1'b0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_quiet_cnt <= '0;
      r_shift0    <= '0;
      r_shift1    <= '0;
      r_sclk      <= 1'b1;
      r_cs        <= 1'b1;
      r_data0     <= '0;
      r_data1     <= '0;
      r_dvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_dvalid    <= w_last;
      r_frame_err <= w_last && (lead_err(w_word0) || lead_err(w_word1));

      if (!io_adc.en)
        r_per_cnt <= '0;
      else if (w_wrap)
        r_per_cnt <= '0;
      else
        r_per_cnt <= r_per_cnt + PER_W'(1);

      // A request landing on the launch cycle is a new request, so set wins over clear.
      if (w_wrap || io_adc.start)
        r_pending <= 1'b1;
      else if (w_launch)
        r_pending <= 1'b0;

      if (w_launch) begin
        r_cs      <= 1'b0;
        r_sclk    <= 1'b1;
        r_div_cnt <= DIV_LOAD;
        r_bit_cnt <= '0;
      end else if (r_state == ST_FRAME) begin
        if (r_div_cnt == '0) begin
          r_div_cnt <= DIV_LOAD;
          r_sclk    <= ~r_sclk;
          if (w_rise) begin
            r_shift0  <= w_word0[FRAME_BITS-2:0];
            r_shift1  <= w_word1[FRAME_BITS-2:0];
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
          if (w_last) begin
            r_cs        <= 1'b1;
            r_quiet_cnt <= QUIET_LOAD;
            r_data0     <= w_word0[ADC_BITS-1:0];
            r_data1     <= w_word1[ADC_BITS-1:0];
          end
        end else begin
          r_div_cnt <= r_div_cnt - DIV_W'(1);
        end
      end else if ((r_state == ST_QUIET) && (r_quiet_cnt != '0)) begin
        r_quiet_cnt <= r_quiet_cnt - QUIET_W'(1);
      end
    end
  end

  hit_holdoff #(.HIT_THRESH(HIT_THRESH), .HOLDOFF(HOLDOFF)) u_hit0 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sample (w_word0[ADC_BITS-1:0]),
    .i_valid  (w_last),
    .o_hit    (io_adc.hit0)
  );

  hit_holdoff #(.HIT_THRESH(HIT_THRESH), .HOLDOFF(HOLDOFF)) u_hit1 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sample (w_word1[ADC_BITS-1:0]),
    .i_valid  (w_last),
    .o_hit    (io_adc.hit1)
  );

  assign io_adc.sclk      = r_sclk;
  assign io_adc.cs        = r_cs;
  assign io_adc.data0     = r_data0;
  assign io_adc.data1     = r_data1;
  assign io_adc.dvalid    = r_dvalid;
  assign io_adc.frame_err = r_frame_err;
  assign io_adc.busy      = r_busy;

endmodule

// File: tb/tb_ad1_sample_ctrl.sv
// Scoreboard bench for ad1_sample_ctrl: an AD1 model serves words per CS frame and predicts samples/hits.
module tb_ad1_sample_ctrl;
  import ad1_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int SP      = 200;
  localparam int QC      = 6;
  localparam int TH      = 800;
  localparam int HO      = 3;

  typedef struct packed {
    logic [11:0] d0;
    logic [11:0] d1;
    logic        ferr;
    logic        h0;
    logic        h1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ad1_sample_ctrl_if bus_if ();

  ad1_sample_ctrl #(
    .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .QUIET_CYC(QC), .HIT_THRESH(TH), .HOLDOFF(HO)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_adc (bus_if.slave)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [15:0] plan0_q[$];
  logic [15:0] plan1_q[$];
  int          dv_times[$];
  int checks = 0;
  int fails  = 0;
  int ign0 = 0, ign1 = 0;
  logic [15:0] cur0 = '0, cur1 = '0;
  int bit_idx = -1;
  int dv_cnt = 0, cyc = 0, rises = 0, low_cnt = 0, high_cnt = 0, hit1_cnt = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, skip_gap = 1'b1;
  logic [4:0] hit0_hist = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w[11:0]  = 12'($urandom_range(0, 4095));
    w[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    return w;
  endfunction

  // AD1 model: a new word per CS fall, bits presented on SCLK falls so each rise sees a stable bit.
  always @(negedge bus_if.cs) begin
    exp_t e;
    cur0 = (plan0_q.size() != 0) ? plan0_q.pop_front() : rand_word();
    cur1 = (plan1_q.size() != 0) ? plan1_q.pop_front() : rand_word();
    e.d0   = cur0[11:0];
    e.d1   = cur1[11:0];
    e.ferr = (cur0[15:12] != 4'h0) || (cur1[15:12] != 4'h0);
    e.h0   = (ign0 == 0) && (int'(cur0[11:0]) >= TH);
    e.h1   = (ign1 == 0) && (int'(cur1[11:0]) >= TH);
    if (e.h0) ign0 = HO; else if (ign0 > 0) ign0--;
    if (e.h1) ign1 = HO; else if (ign1 > 0) ign1--;
    exp_q.push_back(e);
    bit_idx = 15;
  end

  always @(negedge bus_if.sclk) begin
    if (!bus_if.cs && bit_idx >= 0) begin
      bus_if.sdata0 = cur0[bit_idx];
      bus_if.sdata1 = cur1[bit_idx];
      bit_idx--;
    end
  end

  // Monitor: frame shape, gaps and scoreboard pops, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_cs = 1'b1; prev_sclk = 1'b1; rises = 0; low_cnt = 0; high_cnt = 0;
      skip_gap = 1'b1; hit0_hist = '0; hit1_cnt = 0;
    end else begin
      if (bus_if.sclk && !prev_sclk) rises++;
      if (!bus_if.cs && prev_cs) begin
        if (!skip_gap) check("cs_high_gap_ge_quiet", 32'(high_cnt >= QC), 1);
        skip_gap = 1'b0;
        low_cnt = 1;
      end else if (!bus_if.cs) begin
        low_cnt++;
      end else if (bus_if.cs && !prev_cs) begin
        check("frame_sclk_rises", rises, 16);
        check("frame_cs_low_len", low_cnt, 32 * CLK_DIV);
        check("dvalid_at_cs_rise", bus_if.dvalid, 1);
        rises = 0;
        high_cnt = 1;
      end else begin
        high_cnt++;
      end
      if (bus_if.dvalid) begin
        dv_cnt++;
        dv_times.push_back(cyc);
        hit0_hist = {hit0_hist[3:0], bus_if.hit0};
        if (bus_if.hit1) hit1_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_dvalid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data0", bus_if.data0, e.d0);
          check("data1", bus_if.data1, e.d1);
          check("frame_err", bus_if.frame_err, e.ferr);
          check("hit0", bus_if.hit0, e.h0);
          check("hit1", bus_if.hit1, e.h1);
        end
      end else if (bus_if.hit0 || bus_if.hit1 || bus_if.frame_err) begin
        check("pulse_without_dvalid", {bus_if.hit0, bus_if.hit1, bus_if.frame_err}, 0);
      end
      prev_cs = bus_if.cs;
      prev_sclk = bus_if.sclk;
    end
  end

  task automatic pulse_start();
    @(negedge clk) bus_if.start = 1'b1;
    @(negedge clk) bus_if.start = 1'b0;
  endtask

  task automatic wait_dv(input int target, input int budget, input string name);
    int n = 0;
    while (dv_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dv_cnt >= target), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    ign0 = 0; ign1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base, n;
    bus_if.en = 1'b0; bus_if.start = 1'b0; bus_if.sdata0 = 1'b0; bus_if.sdata1 = 1'b0;
    #1 rst = 1'b1;
    #20;
    check("rst_cs", bus_if.cs, 1);
    check("rst_sclk", bus_if.sclk, 1);
    check("rst_data0", bus_if.data0, 0);
    check("rst_data1", bus_if.data1, 0);
    check("rst_dvalid", bus_if.dvalid, 0);
    check("rst_frame_err", bus_if.frame_err, 0);
    check("rst_hits", {bus_if.hit0, bus_if.hit1}, 0);
    check("rst_busy", bus_if.busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single START frame with EN low.
    base = dv_cnt;
    plan0_q.push_back(16'h0ABC); plan1_q.push_back(16'h0123);
    pulse_start();
    repeat (2) @(negedge clk);
    check("busy_in_frame", bus_if.busy, 1);
    wait_dv(base + 1, 300, "single_frame_timeout");
    repeat (200) @(negedge clk);
    check("single_frame_dvalid_count", dv_cnt - base, 1);
    check("busy_after_frame", bus_if.busy, 0);

    // Non-zero leading bit on ch0.
    base = dv_cnt;
    plan0_q.push_back(16'h8FFF); plan1_q.push_back(16'h0000);
    pulse_start();
    wait_dv(base + 1, 300, "frame_err_timeout");

    // Holdoff: five samples of 900 on ch0, ch1 quiet at 100.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      base = dv_cnt;
      plan0_q.push_back(16'd900); plan1_q.push_back(16'd100);
      pulse_start();
      wait_dv(base + 1, 300, "holdoff_frame_timeout");
      repeat (10) @(negedge clk);
    end
    check("hit0_pattern", hit0_hist, 5'b10001);
    check("hit1_count", hit1_cnt, 0);

    // Two STARTs during an active frame coalesce into one extra frame.
    base = dv_cnt;
    pulse_start();
    n = 0;
    while (bus_if.cs && n < 50) begin @(negedge clk); n++; end
    check("cs_fall_timeout", bus_if.cs, 0);
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (600) @(negedge clk);
    check("coalesced_frame_count", dv_cnt - base, 2);

    // Randomised START traffic, some of it overlapping frames.
    for (int i = 0; i < 25; i++) begin
      pulse_start();
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    check("random_queue_drained", exp_q.size(), 0);

    // Periodic sampling: EN high for 10 sample periods.
    base = dv_cnt;
    dv_times.delete();
    @(negedge clk) bus_if.en = 1'b1;
    repeat (2000) @(negedge clk);
    bus_if.en = 1'b0;
    repeat (150) @(negedge clk);
    check("periodic_dvalid_count", dv_cnt - base, 10);
    for (int i = 1; i < dv_times.size(); i++)
      check("periodic_spacing", dv_times[i] - dv_times[i-1], SP);

    // Reset after the 7th SCLK rise of a frame.
    @(negedge clk) bus_if.en = 1'b1;
    n = 0;
    while (bus_if.cs && n < 400) begin @(negedge clk); n++; end
    check("periodic_cs_fall_timeout", bus_if.cs, 0);
    n = 0;
    while (rises < 7 && n < 100) begin @(negedge clk); n++; end
    check("seventh_rise_timeout", rises, 7);
    rst = 1'b1;
    exp_q.delete();
    ign0 = 0; ign1 = 0;
    #1;
    check("abort_cs", bus_if.cs, 1);
    check("abort_sclk", bus_if.sclk, 1);
    check("abort_dvalid", bus_if.dvalid, 0);
    check("abort_busy", bus_if.busy, 0);
    repeat (3) @(negedge clk);
    base = dv_cnt;
    plan0_q.push_back(16'h0555); plan1_q.push_back(16'h0AAA);
    rst = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1 n++;
      if (!bus_if.cs) break;
    end
    check("post_reset_first_frame_delay", n, SP + 1);
    wait_dv(base + 1, 200, "post_reset_frame_timeout");
    bus_if.en = 1'b0;
    repeat (300) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
